// File: rtl/axil_arb_pkg.sv
// axil_arb_pkg: shared types and constants for the AXI4-Lite master arbiter.
// Holds the sequencer state encoding and bus constants.
package axil_arb_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_DONE
   } state_t;

endpackage

// File: rtl/axil_master_arbiter_if.sv
// axil_master_arbiter_if: AXI4-Lite channel bundle (no WSTRB, full words).
// master modport drives AW/W/AR and the B/R ready lines.
interface axil_master_arbiter_if #(
   parameter int ADDR_W = 4
);
   import axil_arb_pkg::*;

   logic [ADDR_W-1:0] AWADDR;
   logic              AWVALID;
   logic              AWREADY;
   logic [DATA_W-1:0] WDATA;
   logic              WVALID;
   logic              WREADY;
   logic [1:0]        BRESP;
   logic              BVALID;
   logic              BREADY;
   logic [ADDR_W-1:0] ARADDR;
   logic              ARVALID;
   logic              ARREADY;
   logic [DATA_W-1:0] RDATA;
   logic [1:0]        RRESP;
   logic              RVALID;
   logic              RREADY;

   modport master (
      output AWADDR, AWVALID, WDATA, WVALID, BREADY,
      output ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID,
      input  ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWVALID, WDATA, WVALID, BREADY,
      input  ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID,
      output ARREADY, RDATA, RRESP, RVALID
   );

endinterface

// File: rtl/axil_rr_arbiter.sv
// axil_rr_arbiter: two-way round-robin, one-hot grant.
// Pointer moves only when the grant is accepted.
module axil_rr_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   // 1 = requester 1 was granted most recently
   logic last;

   // Lone requester wins; contention goes to the one not served last.
   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Start as if requester 1 went last so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last <= 1'b1;
      else if (accept)
         last <= gnt[1];
   end

endmodule

// File: rtl/axil_master_arbiter.sv
// axil_master_arbiter: two requesters onto one AXI4-Lite master port.
// Define AXIL_ARB_ERR_EN to flag nonzero BRESP/RRESP on req_err.
module axil_master_arbiter
   import axil_arb_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic [1:0]             req_valid,
   input  logic [1:0]             req_we,
   input  logic [1:0][ADDR_W-1:0] req_addr,
   input  logic [1:0][DATA_W-1:0] req_wdata,
   output logic [1:0]             req_done,
   output logic [DATA_W-1:0]      req_rdata,
   output logic [1:0]             req_err,
   axil_master_arbiter_if.master  axi
);

   state_t     state;
   logic [1:0] gnt;
   logic [1:0] gnt_q;
   logic       accept;
   logic       sel;
   logic       aw_done;
   logic       w_done;
   logic       aw_fin;
   logic       w_fin;

   assign accept = (state == ST_IDLE) && (req_valid != 2'b00);
   assign sel    = gnt[1];
   assign aw_fin = aw_done | (axi.AWVALID & axi.AWREADY);
   assign w_fin  = w_done | (axi.WVALID & axi.WREADY);

   axil_rr_arbiter u_rr (
      .clk    (ACLK),
      .rst_n  (ARESETn),
      .req    (req_valid),
      .accept (accept),
      .gnt    (gnt)
   );

`ifndef AXIL_ARB_ERR_EN
   logic [3:0] unused_resp;

   assign unused_resp = {axi.BRESP, axi.RRESP};
   assign req_err     = 2'b00;
`endif

   // Transaction sequencer; every AXI and requester output is a register.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state       <= ST_IDLE;
         gnt_q       <= 2'b00;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         axi.AWADDR  <= '0;
         axi.AWVALID <= 1'b0;
         axi.WDATA   <= '0;
         axi.WVALID  <= 1'b0;
         axi.BREADY  <= 1'b0;
         axi.ARADDR  <= '0;
         axi.ARVALID <= 1'b0;
         axi.RREADY  <= 1'b0;
         req_done    <= 2'b00;
         req_rdata   <= '0;
`ifdef AXIL_ARB_ERR_EN
         req_err     <= 2'b00;
`endif
      end else begin
         req_done <= 2'b00;
`ifdef AXIL_ARB_ERR_EN
         req_err  <= 2'b00;
`endif
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  gnt_q   <= gnt;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  if (req_we[sel]) begin
                     state       <= ST_WR;
                     axi.AWADDR  <= req_addr[sel];
                     axi.WDATA   <= req_wdata[sel];
                     axi.AWVALID <= 1'b1;
                     axi.WVALID  <= 1'b1;
                  end else begin
                     state       <= ST_RD_ADDR;
                     axi.ARADDR  <= req_addr[sel];
                     axi.ARVALID <= 1'b1;
                  end
               end
            end
            ST_WR: begin
               if (axi.AWVALID && axi.AWREADY) begin
                  axi.AWVALID <= 1'b0;
                  aw_done     <= 1'b1;
               end
               if (axi.WVALID && axi.WREADY) begin
                  axi.WVALID <= 1'b0;
                  w_done     <= 1'b1;
               end
               if (aw_fin && w_fin) begin
                  state      <= ST_WR_RESP;
                  axi.BREADY <= 1'b1;
               end
            end
            ST_WR_RESP: begin
               if (axi.BVALID) begin
                  state      <= ST_DONE;
                  axi.BREADY <= 1'b0;
                  req_done   <= gnt_q;
                  req_rdata  <= '0;
`ifdef AXIL_ARB_ERR_EN
                  if (axi.BRESP != RESP_OKAY)
                     req_err <= gnt_q;
`endif
               end
            end
            ST_RD_ADDR: begin
               if (axi.ARREADY) begin
                  state       <= ST_RD_DATA;
                  axi.ARVALID <= 1'b0;
                  axi.RREADY  <= 1'b1;
               end
            end
            ST_RD_DATA: begin
               if (axi.RVALID) begin
                  state      <= ST_DONE;
                  axi.RREADY <= 1'b0;
                  req_done   <= gnt_q;
                  req_rdata  <= axi.RDATA;
`ifdef AXIL_ARB_ERR_EN
                  if (axi.RRESP != RESP_OKAY)
                     req_err <= gnt_q;
`endif
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axil_master_arbiter.sv
// tb_axil_master_arbiter: directed vectors against a small AXI-Lite slave.
// Slave READY/VALID delays are set per test through delay variables.
module tb_axil_master_arbiter;
   import axil_arb_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       req_valid = 2'b00;
   logic [1:0]       req_we = 2'b00;
   logic [1:0][3:0]  req_addr = '0;
   logic [1:0][31:0] req_wdata = '0;
   logic [1:0]       req_done;
   logic [31:0]      req_rdata;
   logic [1:0]       req_err;

   int n_chk = 0;
   int n_bad = 0;

   int         aw_delay = 1;
   int         w_delay = 1;
   int         r_delay = 1;
   logic [1:0] r_resp = 2'b00;
   bit         b_hold = 1'b0;

   int          aw_wait, w_wait, r_wait;
   logic        got_aw, got_w, r_pend;
   logic [3:0]  aw_q, ar_q;
   logic [31:0] wd_q;
   logic [31:0] mem [4];
   int          b_hs_n = 0;
   logic        aw_hs, w_hs, fin;

   bit         mon_en = 1'b0;
   logic [3:0] mon_addr = '0;
   int         awv_n, wv_n, addr_bad;

   axil_master_arbiter_if #(.ADDR_W(4)) axi ();

   axil_master_arbiter #(.ADDR_W(4)) dut (
      .ACLK      (clk),
      .ARESETn   (rst_n),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_done  (req_done),
      .req_rdata (req_rdata),
      .req_err   (req_err),
      .axi       (axi)
   );

   always #5 clk = ~clk;

   // Slave: READY after N cycles of VALID (N=1 is immediate).
   assign axi.AWREADY = axi.AWVALID && (aw_wait + 1 >= aw_delay);
   assign axi.WREADY  = axi.WVALID && (w_wait + 1 >= w_delay);
   assign axi.ARREADY = axi.ARVALID;
   assign axi.RVALID  = r_pend && (r_wait + 1 >= r_delay);
   assign axi.RDATA   = mem[ar_q[3:2]];
   assign axi.RRESP   = r_resp;
   assign axi.BRESP   = 2'b00;
   assign aw_hs = axi.AWVALID && axi.AWREADY;
   assign w_hs  = axi.WVALID && axi.WREADY;
   assign fin   = (got_aw || aw_hs) && (got_w || w_hs);

   // Slave state: memory write and B response once both AW and W are taken.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_wait    <= 0;
         w_wait     <= 0;
         r_wait     <= 0;
         got_aw     <= 1'b0;
         got_w      <= 1'b0;
         r_pend     <= 1'b0;
         aw_q       <= '0;
         ar_q       <= '0;
         wd_q       <= '0;
         axi.BVALID <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_wait <= 0;
            got_aw  <= 1'b1;
            aw_q    <= axi.AWADDR;
         end else if (axi.AWVALID) begin
            aw_wait <= aw_wait + 1;
         end
         if (w_hs) begin
            w_wait <= 0;
            got_w  <= 1'b1;
            wd_q   <= axi.WDATA;
         end else if (axi.WVALID) begin
            w_wait <= w_wait + 1;
         end
         if (fin && !axi.BVALID && !b_hold) begin
            axi.BVALID <= 1'b1;
            got_aw     <= 1'b0;
            got_w      <= 1'b0;
            mem[aw_hs ? axi.AWADDR[3:2] : aw_q[3:2]] <=
               w_hs ? axi.WDATA : wd_q;
         end
         if (axi.BVALID && axi.BREADY) begin
            axi.BVALID <= 1'b0;
            b_hs_n     <= b_hs_n + 1;
         end
         if (axi.ARVALID && axi.ARREADY) begin
            r_pend <= 1'b1;
            r_wait <= 0;
            ar_q   <= axi.ARADDR;
         end else if (axi.RVALID && axi.RREADY) begin
            r_pend <= 1'b0;
         end else if (r_pend) begin
            r_wait <= r_wait + 1;
         end
      end
   end

   // Write-channel monitor: VALID cycles and AWADDR stability.
   always @(negedge clk) begin
      if (mon_en) begin
         if (axi.AWVALID) begin
            awv_n++;
            if (axi.AWADDR != mon_addr)
               addr_bad++;
         end
         if (axi.WVALID)
            wv_n++;
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One transaction from an idle DUT; cyc counts grant cycle to done cycle.
   task automatic do_txn(input int r, input logic we, input logic [3:0] a,
                         input logic [31:0] d, output int cyc,
                         output logic [1:0] dn, output logic [31:0] rd,
                         output logic [1:0] er);
      int n;
      n = 0;
      req_we[r]    = we;
      req_addr[r]  = a;
      req_wdata[r] = d;
      req_valid[r] = 1'b1;
      do begin
         @(negedge clk);
         n++;
         if (n == 1)
            req_valid[r] = 1'b0;
      end while (req_done == 2'b00 && n < 60);
      dn  = req_done;
      rd  = req_rdata;
      er  = req_err;
      cyc = n + 1;
      @(negedge clk);
   endtask

   task automatic delay_wr(input string tag, input int awd, input int wd,
                           input logic [3:0] a, input logic [31:0] d);
      int          cyc, b0, hi;
      logic [1:0]  dn, er;
      logic [31:0] rd;
      aw_delay = awd;
      w_delay  = wd;
      awv_n    = 0;
      wv_n     = 0;
      addr_bad = 0;
      mon_addr = a;
      b0       = b_hs_n;
      mon_en   = 1'b1;
      do_txn(0, 1'b1, a, d, cyc, dn, rd, er);
      mon_en   = 1'b0;
      hi = (awd > wd) ? awd : wd;
      check({tag, "_awv"}, awv_n, awd);
      check({tag, "_wv"}, wv_n, wd);
      check({tag, "_addr"}, addr_bad, 0);
      check({tag, "_bhs"}, b_hs_n - b0, 1);
      check({tag, "_done"}, dn, 2'b01);
      check({tag, "_cyc"}, cyc, hi + 3);
      aw_delay = 1;
      w_delay  = 1;
      do_txn(0, 1'b0, a, 32'h0, cyc, dn, rd, er);
      check({tag, "_rback"}, rd, d);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ctl"},
            {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID,
             axi.RREADY, req_done, req_err}, 64'h0);
      check({tag, "_bus"}, {axi.AWADDR, axi.ARADDR, axi.WDATA}, 64'h0);
      check({tag, "_rdata"}, req_rdata, 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc, k, n, seen, b0;
      logic [1:0]  dn, er;
      logic [31:0] rd;
      logic [1:0]  seq [4];
      logic [31:0] rds [4];

      mem[0] = 32'h0;
      mem[1] = 32'h0;
      mem[2] = 32'h0;
      mem[3] = 32'h1234_5678;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Zero-wait write then read back through requester 0.
      b0 = b_hs_n;
      do_txn(0, 1'b1, 4'h4, 32'hDEAD_BEEF, cyc, dn, rd, er);
      check("wr_done", dn, 2'b01);
      check("wr_cyc", cyc, 4);
      check("wr_rdata0", rd, 0);
      check("wr_err", er, 2'b00);
      check("wr_bhs", b_hs_n - b0, 1);
      do_txn(0, 1'b0, 4'h4, 32'h0, cyc, dn, rd, er);
      check("rd_data", rd, 32'hDEAD_BEEF);
      check("rd_done", dn, 2'b01);
      check("rd_cyc", cyc, 4);

      // Requester 1 read with RVALID held off.
      r_delay = 5;
      do_txn(1, 1'b0, 4'hC, 32'h0, cyc, dn, rd, er);
      r_delay = 1;
      check("slow_rd_data", rd, 32'h1234_5678);
      check("slow_rd_done", dn, 2'b10);
      check("slow_rd_cyc", cyc, 8);

      // Independent AW / W handshakes.
      delay_wr("aw3", 3, 1, 4'h8, 32'hA5A5_A5A5);
      delay_wr("w3", 1, 3, 4'h0, 32'h5A5A_0F0F);

      // Error response on a read.
      r_resp = 2'b10;
      do_txn(1, 1'b0, 4'h0, 32'h0, cyc, dn, rd, er);
      r_resp = 2'b00;
      check("err_done", dn, 2'b10);
`ifdef AXIL_ARB_ERR_EN
      check("err_flag", er, 2'b10);
`else
      check("err_flag", er, 2'b00);
`endif

      // Continuous contention right after reset alternates grants.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         seq[i] = 2'b00;
         rds[i] = 32'h0;
      end
      req_we      = 2'b00;
      req_addr[0] = 4'h4;
      req_addr[1] = 4'hC;
      req_valid   = 2'b11;
      k = 0;
      n = 0;
      while (k < 4 && n < 80) begin
         @(negedge clk);
         n++;
         if (req_done != 2'b00) begin
            seq[k] = req_done;
            rds[k] = req_rdata;
            k++;
         end
      end
      req_valid = 2'b00;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rr_seq%0d", i), seq[i],
               (i % 2 == 0) ? 2'b01 : 2'b10);
         check($sformatf("rr_data%0d", i), rds[i],
               (i % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678);
      end

      // Reset while waiting on B drops the write silently.
      b_hold       = 1'b1;
      req_we[0]    = 1'b1;
      req_addr[0]  = 4'h0;
      req_wdata[0] = 32'h0BAD_F00D;
      req_valid    = 2'b01;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1)
            req_valid = 2'b00;
      end while (!axi.BREADY && n < 20);
      check("rm_bready", axi.BREADY, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_quiet("rm");
      @(negedge clk);
      rst_n  = 1'b1;
      b_hold = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (req_done != 2'b00)
            seen++;
      end
      check("rm_nodone", seen, 0);
      check("rm_mem", mem[0], 32'h5A5A_0F0F);
      req_we      = 2'b00;
      req_addr[0] = 4'h4;
      req_addr[1] = 4'hC;
      req_valid   = 2'b11;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (req_done == 2'b00 && n < 20);
      check("rm_first", req_done, 2'b01);
      req_valid = 2'b00;
      repeat (6) @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
